fetch_buffer: RTL and testbench

Instruction prefetch buffer that answers the fetch stage's instruction requests and issues word reads to instruction memory. It sits between the fetch stage and the instruction memory port. It prefetches sequential 32-bit words into a small FIFO and returns a 32-bit, halfword-aligned instruction window, so that compressed and misaligned 32-bit instructions are served without extra memory reads. It flushes and redirects on speculative (trap/mret/jump) requests and on fence.

---
 rtl/fetch_buffer_if.sv | 33 +++
 rtl/fetch_buffer.sv | 161 ++++++++++++++++
 tb/tb_fetch_buffer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch-stage and instruction-memory signals of the prefetch buffer.
// The slave modport is the buffer's view; the master modport is the
// environment (fetch stage plus instruction memory) driving it.
interface fetch_buffer_if;
    logic        fetch_valid;
    logic        fetch_fence;
    logic        fetch_spec;
    logic [1:0]  fetch_mode;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;

    logic        imem_valid;
    logic        imem_fence;
    logic [1:0]  imem_mode;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport slave (
        input  fetch_valid, fetch_fence, fetch_spec, fetch_mode, fetch_addr,
        output fetch_ready, fetch_rdata,
        output imem_valid, imem_fence, imem_mode, imem_addr,
        input  imem_ready, imem_rdata
    );

    modport master (
        output fetch_valid, fetch_fence, fetch_spec, fetch_mode, fetch_addr,
        input  fetch_ready, fetch_rdata,
        input  imem_valid, imem_fence, imem_mode, imem_addr,
        output imem_ready, imem_rdata
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: keeps a small FIFO of sequential 32-bit
// words and serves a halfword-aligned 32-bit instruction window, so that
// compressed and word-straddling instructions need no extra memory reads.
// Redirects, fences and out-of-window fetches flush and restart the stream.
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    fetch_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t        state;
    logic [31:0]   words [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [29:0]   head_addr;
    logic [29:0]   next_addr;
    logic          fence_pend;

    logic [29:0]   w;
    logic [29:0]   off;
    logic [29:0]   off1;
    logic [29:0]   count_ext;
    logic          in_range;
    logic          flush;
    logic          w_hit;
    logic          w1_hit;
    logic [PW-1:0] lo_idx;
    logic [PW-1:0] hi_idx;
    logic [31:0]   word_lo;
    logic [31:0]   word_hi;
    logic [15:0]   lo_half;
    logic [15:0]   hi_half;
    logic          need_hi;
    logic          hit;
    logic          pop;
    logic          push;
    logic          addr_bit0_unused;

    // Halfword addressing ignores bit 0 of the fetch address.
    assign addr_bit0_unused = bus.fetch_addr[0];

    // Window lookup relative to the oldest buffered word, plus flush/pop/push decisions.
    always_comb begin
        w         = bus.fetch_addr[31:2];
        off       = w - head_addr;
        off1      = off + 30'd1;
        count_ext = 30'(count);
        in_range  = (off <= count_ext);
        flush     = bus.fetch_valid & (bus.fetch_spec | bus.fetch_fence | ~in_range);
        w_hit     = (off < count_ext);
        w1_hit    = (off1 < count_ext);
        lo_idx    = rd_ptr + off[PW-1:0];
        hi_idx    = rd_ptr + off1[PW-1:0];
        word_lo   = words[lo_idx];
        word_hi   = words[hi_idx];
        lo_half   = bus.fetch_addr[1] ? word_lo[31:16] : word_lo[15:0];
        if (bus.fetch_addr[1]) begin
            hi_half = w1_hit ? word_hi[15:0] : 16'h0000;
        end else begin
            hi_half = word_lo[31:16];
        end
        need_hi   = (lo_half[1:0] == 2'b11) & bus.fetch_addr[1];
        hit       = bus.fetch_valid & ~flush & w_hit & (~need_hi | w1_hit);
        pop       = bus.fetch_valid & ~flush & (off == 30'd1) & (count != '0);
        push      = (state == S_WAIT) & bus.imem_ready & ~flush;
        bus.fetch_ready = hit;
        bus.fetch_rdata = hit ? {hi_half, lo_half} : 32'h0;
    end

    // Word storage; written only when an in-flight response is accepted.
    always_ff @(posedge clk) begin
        if (push) begin
            words[wr_ptr] <= bus.imem_rdata;
        end
    end

    // FIFO bookkeeping, outstanding-request FSM and registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            head_addr      <= '0;
            next_addr      <= '0;
            fence_pend     <= 1'b0;
            bus.imem_valid <= 1'b0;
            bus.imem_fence <= 1'b0;
            bus.imem_mode  <= 2'b00;
            bus.imem_addr  <= 32'h0;
        end else begin
            bus.imem_mode  <= bus.fetch_mode;
            bus.imem_valid <= 1'b0;
            bus.imem_fence <= 1'b0;

            if (flush) begin
                count     <= '0;
                head_addr <= w;
                next_addr <= w;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                if (bus.fetch_fence) begin
                    fence_pend <= 1'b1;
                end
            end else begin
                if (pop) begin
                    head_addr <= head_addr + 30'd1;
                    rd_ptr    <= rd_ptr + PW'(1);
                end
                if (push) begin
                    next_addr <= next_addr + 30'd1;
                    wr_ptr    <= wr_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end

            case (state)
                S_IDLE: begin
                    if (flush) begin
                        bus.imem_valid <= 1'b1;
                        bus.imem_fence <= bus.fetch_fence | fence_pend;
                        bus.imem_addr  <= {w, 2'b00};
                        fence_pend     <= 1'b0;
                        state          <= S_WAIT;
                    end else if (count < FULL) begin
                        bus.imem_valid <= 1'b1;
                        bus.imem_fence <= fence_pend;
                        bus.imem_addr  <= {next_addr, 2'b00};
                        fence_pend     <= 1'b0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= bus.imem_ready ? S_IDLE : S_DROP;
                    end else if (bus.imem_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (bus.imem_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: stimulus queues the expected memory
// requests and fetch windows, a negedge monitor pops and compares them
// whenever the buffer presents imem_valid or fetch_ready.
module tb_fetch_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fetch_buffer_if bus ();

    fetch_buffer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_img [0:255];
    logic [31:0] fetch_q [$];
    logic [32:0] imem_q  [$];
    bit          mem_hold = 1'b0;
    bit          pending  = 1'b0;
    logic [31:0] paddr    = 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: compare every presented request/window with the scoreboard head.
    always @(negedge clk) begin
        logic [32:0] e;
        logic [31:0] d;
        if (rst === 1'b0) begin
            if (bus.imem_valid === 1'b1) begin
                if (imem_q.size() == 0) begin
                    checkOutput("imem_unexpected_addr", bus.imem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = imem_q.pop_front();
                    checkOutput("imem_addr", bus.imem_addr, e[31:0]);
                    checkOutput("imem_fence", {31'b0, bus.imem_fence}, {31'b0, e[32]});
                end
            end
            if (bus.fetch_ready === 1'b1) begin
                if (fetch_q.size() == 0) begin
                    checkOutput("fetch_unexpected_ready", {31'b0, bus.fetch_ready}, 32'h0);
                end else begin
                    d = fetch_q.pop_front();
                    checkOutput("fetch_rdata", bus.fetch_rdata, d);
                end
            end
        end
    end

    // Memory model: answers each request one cycle after it is seen, unless held.
    always @(posedge clk) begin
        #1;
        bus.imem_ready = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (pending && !mem_hold) begin
                bus.imem_ready = 1'b1;
                bus.imem_rdata = mem_img[paddr[9:2]];
                pending        = 1'b0;
            end
            if (bus.imem_valid === 1'b1) begin
                pending = 1'b1;
                paddr   = bus.imem_addr;
            end
        end
    end

    task automatic fillMem();
        for (int i = 0; i < 256; i++) begin
            mem_img[i] = 32'hA500_0000 | (i << 2);
        end
    endtask

    task automatic expectReq(input logic fence, input logic [31:0] addr);
        imem_q.push_back({fence, addr});
    endtask

    // One cycle of fetch-side stimulus; a miss is checked directly, a hit is queued.
    task automatic applyStimulus(input logic v, input logic s, input logic f,
                                 input logic [31:0] a, input bit exp_rdy,
                                 input logic [31:0] exp_data);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.fetch_valid = v;
        bus.fetch_spec  = s;
        bus.fetch_fence = f;
        bus.fetch_addr  = a;
        if (exp_rdy) fetch_q.push_back(exp_data);
        @(negedge clk);
        if (!exp_rdy) begin
            checkOutput("fetch_ready_low", {31'b0, bus.fetch_ready}, 32'h0);
            checkOutput("fetch_rdata_zero", bus.fetch_rdata, 32'h0);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst             = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_spec  = 1'b0;
        bus.fetch_fence = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_imem_valid", {31'b0, bus.imem_valid}, 32'h0);
        checkOutput("rst_imem_fence", {31'b0, bus.imem_fence}, 32'h0);
        checkOutput("rst_imem_mode", {30'b0, bus.imem_mode}, 32'h0);
        checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
        checkOutput("rst_fetch_ready", {31'b0, bus.fetch_ready}, 32'h0);
        checkOutput("rst_fetch_rdata", bus.fetch_rdata, 32'h0);
    endtask

    task automatic endTest(input string name);
        checkOutput({name, "_imem_left"}, 32'(imem_q.size()), 32'h0);
        checkOutput({name, "_fetch_left"}, 32'(fetch_q.size()), 32'h0);
        imem_q.delete();
        fetch_q.delete();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_spec  = 1'b0;
        bus.fetch_fence = 1'b0;
        bus.fetch_mode  = 2'b00;
        bus.fetch_addr  = 32'h0;
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = 32'h0;

        // Reset then fetch 0x0; prefetch runs until four words are buffered.
        $display("[TB] reset then fetch 0x0, fill to full");
        fillMem();
        mem_img[0] = 32'h00A0_0093;
        expectReq(1'b0, 32'h0); expectReq(1'b0, 32'h4);
        expectReq(1'b0, 32'h8); expectReq(1'b0, 32'hC);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00A0_0093);
        idleCycles(16);
        endTest("full");

        // Compressed stream with a pop, then an out-of-window fetch.
        $display("[TB] compressed stream");
        fillMem();
        mem_img[0] = 32'h4501_4501;
        mem_img[1] = 32'h8082_4505;
        expectReq(1'b0, 32'h0); expectReq(1'b0, 32'h4); expectReq(1'b0, 32'h8);
        expectReq(1'b0, 32'h0); expectReq(1'b0, 32'h4);
        expectReq(1'b0, 32'h8); expectReq(1'b0, 32'hC);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4501_4501);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h2, 1'b1, 32'h0000_4501);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h8082_4505);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h8082_4505);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idleCycles(16);
        endTest("compressed");

        // Misaligned 32-bit instruction straddling words 0 and 1.
        $display("[TB] misaligned instruction");
        fillMem();
        mem_img[0] = 32'h0093_4501;
        mem_img[1] = 32'h1234_00A0;
        expectReq(1'b0, 32'h0); expectReq(1'b0, 32'h4);
        expectReq(1'b0, 32'h8); expectReq(1'b0, 32'hC);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h2, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h2, 1'b0, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h2, 1'b1, 32'h00A0_0093);
        idleCycles(16);
        endTest("misaligned");

        // Redirect while a request is outstanding; its late data must be dropped.
        $display("[TB] redirect with outstanding request");
        fillMem();
        mem_img[0]    = 32'h1111_1111;
        mem_img[8'h40] = 32'h00B0_0113;
        expectReq(1'b0, 32'h0);   expectReq(1'b0, 32'h100); expectReq(1'b0, 32'h104);
        expectReq(1'b0, 32'h0);   expectReq(1'b0, 32'h4);
        expectReq(1'b0, 32'h8);   expectReq(1'b0, 32'hC);
        mem_hold = 1'b1;
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
        mem_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h00B0_0113);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idleCycles(16);
        endTest("redirect");

        // Fence on a full buffer, then mode forwarding.
        $display("[TB] fence and mode");
        fillMem();
        expectReq(1'b0, 32'h0);  expectReq(1'b0, 32'h4);
        expectReq(1'b0, 32'h8);  expectReq(1'b0, 32'hC);
        expectReq(1'b1, 32'h10); expectReq(1'b0, 32'h14);
        expectReq(1'b0, 32'h18); expectReq(1'b0, 32'h1C);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        idleCycles(14);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0);
        idleCycles(16);
        endTest("fence");
        @(posedge clk);
        #1;
        bus.fetch_mode = 2'b10;
        @(negedge clk);
        checkOutput("imem_mode_before", {30'b0, bus.imem_mode}, 32'h0);
        @(negedge clk);
        checkOutput("imem_mode_after", {30'b0, bus.imem_mode}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
